// File: rtl/systolic_result_drain_if.sv
// Output stream of the systolic result drain: one tagged element per valid/ready beat.
interface systolic_result_drain_if #(
  parameter int ELEM_W = 32
);
  logic              m_valid;
  logic              m_ready;
  logic [ELEM_W-1:0] m_data;
  logic [1:0]        m_row;
  logic [1:0]        m_col;
  logic              m_last;

  modport master (
    output m_valid, m_data, m_row, m_col, m_last,
    input  m_ready
  );

  modport slave (
    input  m_valid, m_data, m_row, m_col, m_last,
    output m_ready
  );
endinterface

// File: rtl/systolic_result_drain.sv
// Captures the 4x4 systolic array result on a rising done edge and streams it out
// row-major, one element per beat; a result arriving mid-drain is dropped and flagged.
module systolic_result_drain #(
  parameter int ELEM_W = 32,
  parameter int DIM    = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [DIM*DIM*ELEM_W-1:0] y_in,
  input  logic                      done_in,
  systolic_result_drain_if.master   m,
  output logic                      busy,
  output logic                      overrun,
  input  logic                      clear_overrun
);
  // state | meaning
  // IDLE  | nothing held, waiting for a rising edge of done_in
  // DRAIN | holding register valid, presenting element idx_q

  localparam int N   = DIM * DIM;
  localparam int TOT = N * ELEM_W;
  localparam int IW  = $clog2(N);

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t          state_q;
  logic [IW-1:0]   idx_q;
  logic            done_q;
  logic [TOT-1:0]  hold_q;
  logic            overrun_q;

  logic cap;
  logic hs;
  logic last_idx;
  logic ovr_set;

  assign cap      = done_in & ~done_q;
  assign hs       = m.m_valid & m.m_ready;
  assign last_idx = (idx_q == IW'(N - 1));
  // A capture on the final handshake re-arms instead of being dropped.
  assign ovr_set  = cap & (state_q == DRAIN) & ~(hs & last_idx);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      done_q    <= 1'b0;
      hold_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      done_q <= done_in;

      if (ovr_set)
        overrun_q <= 1'b1;
      else if (clear_overrun)
        overrun_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (cap) begin
            hold_q  <= y_in;
            idx_q   <= '0;
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (hs) begin
            if (!last_idx) begin
              idx_q <= idx_q + 1'b1;
            end else if (cap) begin
              hold_q <= y_in;
              idx_q  <= '0;
            end else begin
              idx_q   <= '0;
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m.m_valid = (state_q == DRAIN);
  assign m.m_data  = hold_q[TOT-1-ELEM_W*int'(idx_q) -: ELEM_W];
  assign m.m_row   = idx_q[3:2];
  assign m.m_col   = idx_q[1:0];
  assign m.m_last  = m.m_valid & last_idx;
  assign busy      = (state_q == DRAIN);
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_systolic_result_drain.sv
// Scoreboard bench for systolic_result_drain: directed frames push expected beats,
// a negedge monitor compares whatever the DUT presents against the queue head.
module tb_systolic_result_drain;
  typedef struct packed {
    logic [31:0] d;
    logic [1:0]  r;
    logic [1:0]  c;
    logic        l;
  } beat_t;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [511:0] y_in = '0;
  logic         done_in = 1'b0;
  logic         busy;
  logic         overrun;
  logic         clear_overrun = 1'b0;

  int errors = 0;
  int checks = 0;

  beat_t       sb_q[$];
  logic [31:0] ea[16];

  systolic_result_drain_if #(.ELEM_W(32)) mif ();

  systolic_result_drain #(.ELEM_W(32), .DIM(4)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .y_in          (y_in),
    .done_in       (done_in),
    .m             (mif),
    .busy          (busy),
    .overrun       (overrun),
    .clear_overrun (clear_overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_y();
    for (int k = 0; k < 16; k++)
      y_in[511-32*k -: 32] = ea[k];
  endtask

  task automatic load_frame();
    beat_t b;
    set_y();
    for (int k = 0; k < 16; k++) begin
      b.d = ea[k];
      b.r = 2'(k / 4);
      b.c = 2'(k % 4);
      b.l = (k == 15);
      sb_q.push_back(b);
    end
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 200; i++) begin
      if (sb_q.size() == 0) break;
      cyc();
    end
    chk(name, 64'(sb_q.size()), 64'd0);
  endtask

  // Monitor: every presented beat must match the queue head; stalled beats are re-checked, so
  // a value that changes during a stall is caught, and a beat pops only when accepted.
  initial begin
    beat_t got;
    forever begin
      @(negedge clk);
      if (mif.m_valid === 1'b1) begin
        got = '{d: mif.m_data, r: mif.m_row, c: mif.m_col, l: mif.m_last};
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got data %0h row %0d col %0d with nothing expected at %0t",
                   got.d, got.r, got.c, $time);
        end else begin
          chk("beat", 64'(got), 64'(sb_q[0]));
          if (mif.m_ready === 1'b1) void'(sb_q.pop_front());
        end
      end
    end
  end

  initial begin
    mif.m_ready = 1'b1;

    // Reset values
    repeat (3) cyc();
    chk("rst_valid",   64'(mif.m_valid), 64'd0);
    chk("rst_busy",    64'(busy),        64'd0);
    chk("rst_overrun", 64'(overrun),     64'd0);
    chk("rst_data",    64'(mif.m_data),  64'd0);
    chk("rst_rowcol",  64'({mif.m_row, mif.m_col}), 64'd0);
    chk("rst_last",    64'(mif.m_last),  64'd0);
    reset_n = 1'b1;
    repeat (3) cyc();
    chk("idle_ready_no_effect", 64'(mif.m_valid), 64'd0);

    // Basic drain: element k = k+1
    for (int k = 0; k < 16; k++) ea[k] = 32'(k + 1);
    load_frame();
    done_in = 1'b1;
    cyc();
    done_in = 1'b0;
    chk("latency_valid", 64'(mif.m_valid), 64'd1);
    chk("first_data",    64'(mif.m_data),  64'd1);
    chk("first_busy",    64'(busy),        64'd1);
    wait_drain("basic_drain");
    chk("basic_busy_low", 64'(busy), 64'd0);

    // Sign and backpressure: ready pattern 1-0-0-1
    for (int k = 0; k < 16; k++) ea[k] = 32'h8000_0000 ^ (32'(k) * 32'h0101_0101);
    ea[6] = 32'hFFFF_FF85;
    load_frame();
    done_in = 1'b1;
    cyc();
    done_in = 1'b0;
    for (int i = 0; i < 200 && sb_q.size() != 0; i++) begin
      mif.m_ready = (i % 4 == 0) || (i % 4 == 3);
      cyc();
    end
    chk("bp_drain", 64'(sb_q.size()), 64'd0);
    mif.m_ready = 1'b1;
    cyc();
    chk("bp_busy_low", 64'(busy), 64'd0);

    // Level done held for 40 cycles gives one frame
    for (int k = 0; k < 16; k++) ea[k] = 32'h0055_0000 + 32'(k);
    load_frame();
    done_in = 1'b1;
    repeat (40) cyc();
    done_in = 1'b0;
    repeat (5) cyc();
    chk("level_drain",   64'(sb_q.size()), 64'd0);
    chk("level_overrun", 64'(overrun),     64'd0);
    chk("level_busy",    64'(busy),        64'd0);

    // Overrun: second edge mid-drain, together with clear (set wins)
    for (int k = 0; k < 16; k++) ea[k] = 32'hA000_0000 + 32'(k);
    load_frame();
    done_in = 1'b1;
    cyc();
    done_in = 1'b0;
    repeat (5) cyc();
    for (int k = 0; k < 16; k++) ea[k] = 32'hB000_0000 + 32'(k);
    set_y();
    done_in = 1'b1;
    clear_overrun = 1'b1;
    cyc();
    done_in = 1'b0;
    clear_overrun = 1'b0;
    chk("ovr_set_beats_clear", 64'(overrun), 64'd1);
    wait_drain("ovr_orig_data");
    repeat (3) cyc();
    chk("ovr_sticky", 64'(overrun), 64'd1);
    chk("ovr_busy",   64'(busy),    64'd0);
    clear_overrun = 1'b1;
    chk("ovr_before_clear_edge", 64'(overrun), 64'd1);
    cyc();
    clear_overrun = 1'b0;
    chk("ovr_cleared", 64'(overrun), 64'd0);

    // Re-arm: rising done edge on the final handshake
    for (int k = 0; k < 16; k++) ea[k] = 32'hC000_0000 + 32'(k);
    load_frame();
    done_in = 1'b1;
    cyc();
    done_in = 1'b0;
    repeat (15) cyc();
    chk("rearm_at_last", 64'(mif.m_last), 64'd1);
    for (int k = 0; k < 16; k++) ea[k] = 32'hD000_0000 + 32'(k);
    load_frame();
    done_in = 1'b1;
    cyc();
    done_in = 1'b0;
    chk("rearm_busy",    64'(busy),       64'd1);
    chk("rearm_data",    64'(mif.m_data), 64'hD000_0000);
    chk("rearm_overrun", 64'(overrun),    64'd0);
    wait_drain("rearm_drain");
    chk("rearm_overrun_end", 64'(overrun), 64'd0);

    // Reset mid-drain
    for (int k = 0; k < 16; k++) ea[k] = 32'hE000_0000 + 32'(k);
    load_frame();
    done_in = 1'b1;
    cyc();
    done_in = 1'b0;
    repeat (7) cyc();
    reset_n = 1'b0;
    #1;
    sb_q.delete();
    chk("midrst_valid",   64'(mif.m_valid), 64'd0);
    chk("midrst_busy",    64'(busy),        64'd0);
    chk("midrst_overrun", 64'(overrun),     64'd0);
    repeat (2) cyc();
    reset_n = 1'b1;
    repeat (20) cyc();
    chk("post_rst_quiet", 64'(mif.m_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule

// File: doc/systolic_result_drain.md
# systolic_result_drain

Downstream stage of the 4x4 systolic matrix-multiply array. It captures the 512-bit result vector when the array raises its done flag. It then streams the 16 signed 32-bit partial sums out one element per beat on a valid/ready interface, in row-major order with row/column tags and a last marker. While the block drains, `busy` is asserted so the upstream controller can hold off a new `valid_in`. A result completed during a drain is dropped and flagged.

## Interface
- `ELEM_W`, default 32: width of one result element.
- `DIM`, default 4: matrix dimension; the block holds DIM*DIM elements. Only 4 is supported and verified.
- `clk`  input  1  single clock; all state updates on its rising edge.
- `reset_n`  input  1  asynchronous, active-low reset.
- `y_in`  input  512  result vector from the array; element (r,c) at bits [511-32*(4r+c) -: 32].
- `done_in`  input  1  array done flag; level signal, may stay high across several cycles.
- `m_valid`  output  1  output element valid.
- `m_ready`  input  1  downstream accepts the element.
- `m_data`  output  32  signed element value.
- `m_row`  output  2  row index of `m_data`.
- `m_col`  output  2  column index of `m_data`.
- `m_last`  output  1  high on element (3,3).
- `busy`  output  1  high while a captured result is not fully drained.
- `overrun`  output  1  sticky; a result was dropped.
- `clear_overrun`  input  1  synchronous clear of `overrun`.

## Operation
- Edge detect: `done_q` registers `done_in`, reset 0. A capture event is `done_in & ~done_q`. A level that is held high produces one event only.
- FSM states:
  - IDLE to DRAIN on a capture event. In that cycle `y_in` is loaded into a 512-bit holding register and `idx` is set to 0.
  - DRAIN to DRAIN on a handshake (`m_valid & m_ready`) with idx < 15; `idx` increments.
  - DRAIN to IDLE on a handshake with idx == 15.
  - DRAIN to DRAIN (re-arm) on a handshake with idx == 15 and a capture event in the same cycle. The new `y_in` is loaded, `idx` returns to 0, and no overrun is flagged.
  - A capture event in DRAIN that is not on the final handshake sets `overrun`. The holding register is left unchanged and the new result is discarded.
- Outputs:
  - `m_valid` = (state == DRAIN).
  - `m_data` = holding[511-32*idx -: 32].
  - `m_row` = idx[3:2], `m_col` = idx[1:0].
  - `m_last` = m_valid & (idx == 15).
  - `busy` = (state == DRAIN).
- Stall: while `m_valid & ~m_ready`, `m_data`, `m_row`, `m_col`, `m_last` and `idx` hold stable.
- Overrun flag: set has priority over `clear_overrun` when both occur in the same cycle. Otherwise `clear_overrun` clears it on the next edge.
- No arithmetic: elements pass through bit-exact, including sign.

## Timing
- Reset values (asynchronous on `reset_n` = 0):
  - state IDLE, `idx` 0, `done_q` 0, holding register 0.
  - `m_valid`, `m_last`, `busy`, `overrun` all 0.
  - `m_data` 0, `m_row` 0, `m_col` 0.
- Reset deassertion is assumed synchronous to `clk` by the surrounding design. If `done_in` is already high at deassertion, that counts as a capture event on the first edge.
- Latency:
  - Capture edge E: `m_valid` is high in the cycle after E, showing element (0,0).
  - With `m_ready` held high, elements are presented on 16 consecutive cycles, and `busy` falls after the 16th handshake edge.
  - Minimum spacing between accepted results is 16 cycles, reached only via the same-cycle re-arm case.
- Reset mid-drain: the drain is aborted immediately, nothing further is emitted, and the next capture needs a new rising edge of `done_in`.
- `m_ready` may be asserted before `m_valid` rises; this has no effect in IDLE.

## Test plan
- Basic drain: load y with element k = k+1 (k = 0..15), pulse `done_in`, hold `m_ready` = 1. Expect 16 beats with data 1..16, (row,col) (0,0)..(3,3), `m_last` only on data 16, and `busy` low afterwards.
- Sign and backpressure: set element (1,2) = 32'hFFFF_FF85 (-123) and toggle `m_ready` in a 1-0-0-1 pattern. Expect every value delivered exactly once, bit-exact, and stable across stalls.
- Level done: hold `done_in` high for 40 cycles. Expect exactly one 16-beat frame and `overrun` to stay 0.
- Overrun: assert a second rising edge of `done_in` at beat 5 with different y. Expect the frame to finish with the original data and `overrun` = 1 until `clear_overrun` is pulsed, which gives 0 one cycle later.
- Re-arm: time a rising edge of `done_in` to coincide with the handshake of beat 15. Expect the next cycle to present element (0,0) of the new y, `busy` to stay high, and `overrun` = 0.
- Reset mid-drain: pull `reset_n` low at beat 7. Expect `m_valid`, `busy` and `overrun` = 0 immediately. After release, with `done_in` low, expect no output.
